// File: rtl/rpg_file.sv
// rpg_file: a bank of NUM_REGS registers with one write port and two
// registered read ports. Each cycle the write source is chosen from the
// immediate, the ALU or memory. Every performed write also updates the
// {Z,C,N} flags.
//
// Write qualifier: a write is "performed" when iSelect != 0 and iWrAddr is
// below NUM_REGS. A performed write always updates oFlags and pulses oWrDone
// one cycle later. It stores data only when it is not aimed at a hard-wired
// zero register 0. There is no back-pressure, so every request is accepted
// in the cycle it is presented.
module rpg_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REGS   = 8,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG0  = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [1:0]            iSelect,
  input  logic [ADDR_WIDTH-1:0] iWrAddr,
  input  logic [DATA_WIDTH-1:0] iInm,
  input  logic [DATA_WIDTH:0]   iAlu,
  input  logic [DATA_WIDTH-1:0] iMem,
  input  logic [ADDR_WIDTH-1:0] iRdAddrA,
  input  logic [ADDR_WIDTH-1:0] iRdAddrB,
  output logic [DATA_WIDTH-1:0] oRdDataA,
  output logic [DATA_WIDTH-1:0] oRdDataB,
  output logic [2:0]            oFlags,
  output logic                  oWrDone
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_carry;
  logic                  wr_performed;
  logic                  wr_store;
  logic [DATA_WIDTH-1:0] next_a;
  logic [DATA_WIDTH-1:0] next_b;

  // Select the write source and decide whether the write is performed and stored.
  always_comb begin
    wr_data  = '0;
    wr_carry = 1'b0;
    case (iSelect)
      2'd1: wr_data = iInm;
      2'd2: begin
        wr_data  = iAlu[DATA_WIDTH-1:0];
        wr_carry = iAlu[DATA_WIDTH];
      end
      2'd3: wr_data = iMem;
      default: wr_data = '0;
    endcase
    wr_performed = (iSelect != 2'd0) && (32'(iWrAddr) < NUM_REGS);
    // A write to a hard-wired zero register 0 still counts for flags but stores nothing.
    wr_store = wr_performed && !((ZERO_REG0 != 0) && (iWrAddr == '0));
  end

  // Read muxes: the old contents, forced to zero where required, then the bypass of a stored write.
  always_comb begin
    next_a = '0;
    next_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(iRdAddrA) == i) next_a = regs[i];
      if (32'(iRdAddrB) == i) next_b = regs[i];
    end
    if ((ZERO_REG0 != 0) && (iRdAddrA == '0)) next_a = '0;
    if ((ZERO_REG0 != 0) && (iRdAddrB == '0)) next_b = '0;
    // wr_store already excludes out-of-range and zero-register writes, so those never bypass.
    if ((BYPASS != 0) && wr_store && (iRdAddrA == iWrAddr)) next_a = wr_data;
    if ((BYPASS != 0) && wr_store && (iRdAddrB == iWrAddr)) next_b = wr_data;
  end

  // Register bank storage; reset clears every entry and wins over a same-cycle write.
  always_ff @(posedge Clock) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (Reset) begin
        regs[i] <= '0;
      end else if (wr_store && (32'(iWrAddr) == i)) begin
        regs[i] <= wr_data;
      end
    end
  end

  // Registered read data, flags and write-done pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oRdDataA <= '0;
      oRdDataB <= '0;
      oFlags   <= 3'b000;
      oWrDone  <= 1'b0;
    end else begin
      oRdDataA <= next_a;
      oRdDataB <= next_b;
      oWrDone  <= wr_performed;
      if (wr_performed) begin
        oFlags <= {~|wr_data, wr_carry, wr_data[DATA_WIDTH-1]};
      end
    end
  end

endmodule

// File: tb/tb_rpg_file.sv
// Bench for rpg_file. Four instances share one stimulus stream:
//   0: defaults, 1: BYPASS=0, 2: ZERO_REG0=1, 3: NUM_REGS=6.
// A behavioural model of the register file, built from the architectural
// rules, is compared every cycle. Directed steps add literal expectations.
module tb_rpg_file;

  logic       Clock;
  logic       Reset;
  logic [1:0] sel;
  logic [2:0] wr_addr;
  logic [7:0] inm;
  logic [8:0] alu;
  logic [7:0] mem;
  logic [2:0] ra;
  logic [2:0] rb;

  logic [7:0] rd_a  [4];
  logic [7:0] rd_b  [4];
  logic [2:0] flags [4];
  logic       done  [4];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  rpg_file #(.NUM_REGS(8), .BYPASS(1), .ZERO_REG0(0)) u0 (
    .Clock(Clock), .Reset(Reset), .iSelect(sel), .iWrAddr(wr_addr), .iInm(inm),
    .iAlu(alu), .iMem(mem), .iRdAddrA(ra), .iRdAddrB(rb),
    .oRdDataA(rd_a[0]), .oRdDataB(rd_b[0]), .oFlags(flags[0]), .oWrDone(done[0]));
  rpg_file #(.NUM_REGS(8), .BYPASS(0), .ZERO_REG0(0)) u1 (
    .Clock(Clock), .Reset(Reset), .iSelect(sel), .iWrAddr(wr_addr), .iInm(inm),
    .iAlu(alu), .iMem(mem), .iRdAddrA(ra), .iRdAddrB(rb),
    .oRdDataA(rd_a[1]), .oRdDataB(rd_b[1]), .oFlags(flags[1]), .oWrDone(done[1]));
  rpg_file #(.NUM_REGS(8), .BYPASS(1), .ZERO_REG0(1)) u2 (
    .Clock(Clock), .Reset(Reset), .iSelect(sel), .iWrAddr(wr_addr), .iInm(inm),
    .iAlu(alu), .iMem(mem), .iRdAddrA(ra), .iRdAddrB(rb),
    .oRdDataA(rd_a[2]), .oRdDataB(rd_b[2]), .oFlags(flags[2]), .oWrDone(done[2]));
  rpg_file #(.NUM_REGS(6), .BYPASS(1), .ZERO_REG0(0)) u3 (
    .Clock(Clock), .Reset(Reset), .iSelect(sel), .iWrAddr(wr_addr), .iInm(inm),
    .iAlu(alu), .iMem(mem), .iRdAddrA(ra), .iRdAddrB(rb),
    .oRdDataA(rd_a[3]), .oRdDataB(rd_b[3]), .oFlags(flags[3]), .oWrDone(done[3]));

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- behavioural model ----------------
  logic [7:0] m_regs  [4][8];
  logic [2:0] m_flags [4];
  logic       m_done  [4];
  logic [7:0] m_rda   [4];
  logic [7:0] m_rdb   [4];

  function automatic int nregs_of(int k);
    return (k == 3) ? 6 : 8;
  endfunction
  function automatic bit byp_of(int k);
    return (k != 1);
  endfunction
  function automatic bit z0_of(int k);
    return (k == 2);
  endfunction

  function automatic logic [7:0] wval();
    case (sel)
      2'd1:    return inm;
      2'd2:    return alu[7:0];
      2'd3:    return mem;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit performed(int k);
    return (sel != 2'd0) && (int'(wr_addr) < nregs_of(k));
  endfunction

  function automatic bit stores(int k);
    return performed(k) && !(z0_of(k) && wr_addr == 3'd0);
  endfunction

  function automatic logic [7:0] model_read(int k, logic [2:0] a);
    if (int'(a) >= nregs_of(k)) return 8'h00;
    if (z0_of(k) && a == 3'd0) return 8'h00;
    if (byp_of(k) && stores(k) && a == wr_addr) return wval();
    return m_regs[k][a];
  endfunction

  // Model state advances on the active edge from the inputs held across it.
  always @(posedge Clock) begin
    for (int k = 0; k < 4; k++) begin
      if (Reset) begin
        for (int j = 0; j < 8; j++) m_regs[k][j] <= 8'h00;
        m_flags[k] <= 3'b000;
        m_done[k]  <= 1'b0;
        m_rda[k]   <= 8'h00;
        m_rdb[k]   <= 8'h00;
      end else begin
        m_rda[k]  <= model_read(k, ra);
        m_rdb[k]  <= model_read(k, rb);
        m_done[k] <= performed(k);
        if (performed(k)) begin
          m_flags[k] <= {wval() == 8'h00, (sel == 2'd2) ? alu[8] : 1'b0, wval() >= 8'h80};
          if (stores(k)) m_regs[k][wr_addr] <= wval();
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, compare all instances against the model away from the active edge.
  always @(negedge Clock) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("model_rd_a[%0d]", k), 32'(rd_a[k]), 32'(m_rda[k]));
        check($sformatf("model_rd_b[%0d]", k), 32'(rd_b[k]), 32'(m_rdb[k]));
        check($sformatf("model_flags[%0d]", k), 32'(flags[k]), 32'(m_flags[k]));
        check($sformatf("model_done[%0d]", k), 32'(done[k]), 32'(m_done[k]));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [1:0] s, input logic [2:0] wa, input logic [7:0] im,
                       input logic [8:0] al, input logic [7:0] me,
                       input logic [2:0] a, input logic [2:0] b);
    sel = s; wr_addr = wa; inm = im; alu = al; mem = me; ra = a; rb = b;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    Reset = 1'b1;
    sel = 2'd0; wr_addr = 3'd0; inm = 8'h00; alu = 9'h000; mem = 8'h00; ra = 3'd0; rb = 3'd0;
    repeat (2) @(negedge Clock);
    chk_en = 1'b1;
    Reset  = 1'b0;

    // After reset every register reads 0 on both ports, with no flags and no done pulse.
    for (int a = 0; a < 8; a++) begin
      drive(2'd0, 3'd0, 8'h00, 9'h000, 8'h00, 3'(a), 3'(7 - a));
      check("rst_rd_a", 32'(rd_a[0]), 32'h00);
      check("rst_rd_b", 32'(rd_b[0]), 32'h00);
    end
    check("rst_flags", 32'(flags[0]), 32'h0);
    check("rst_done", 32'(done[0]), 32'h0);

    // Basic writes with flag generation.
    drive(2'd1, 3'd3, 8'h80, 9'h000, 8'h00, 3'd0, 3'd0);
    check("wr3_flags_N", 32'(flags[0]), 32'h1);
    check("wr3_done", 32'(done[0]), 32'h1);
    drive(2'd2, 3'd4, 8'h00, 9'h100, 8'h00, 3'd0, 3'd0);
    check("wr4_flags_ZC", 32'(flags[0]), 32'h6);
    drive(2'd0, 3'd0, 8'h00, 9'h000, 8'h00, 3'd3, 3'd4);
    check("rd3", 32'(rd_a[0]), 32'h80);
    check("rd4", 32'(rd_b[0]), 32'h00);
    check("hold_done", 32'(done[0]), 32'h0);
    check("hold_flags", 32'(flags[0]), 32'h6);

    // Read during write, with and without bypass.
    drive(2'd1, 3'd2, 8'h11, 9'h000, 8'h00, 3'd0, 3'd0);
    drive(2'd1, 3'd2, 8'h5A, 9'h000, 8'h00, 3'd2, 3'd0);
    check("bypass_on", 32'(rd_a[0]), 32'h5A);
    check("bypass_off", 32'(rd_a[1]), 32'h11);
    drive(2'd0, 3'd0, 8'h00, 9'h000, 8'h00, 3'd2, 3'd0);
    check("bypass_off_next", 32'(rd_a[1]), 32'h5A);

    // Hard-wired zero register.
    drive(2'd3, 3'd0, 8'h00, 9'h000, 8'h00, 3'd0, 3'd0);
    check("z0_flags_Z", 32'(flags[2]), 32'h4);
    check("z0_done", 32'(done[2]), 32'h1);
    check("z0_rd", 32'(rd_a[2]), 32'h00);
    drive(2'd3, 3'd0, 8'h00, 9'h000, 8'h7F, 3'd0, 3'd0);
    check("z0_flags_7f", 32'(flags[2]), 32'h0);
    check("z0_rd_nobyp", 32'(rd_a[2]), 32'h00);
    drive(2'd0, 3'd0, 8'h00, 9'h000, 8'h00, 3'd0, 3'd0);
    check("z0_rd_after", 32'(rd_a[2]), 32'h00);
    check("r0_normal", 32'(rd_a[0]), 32'h7F);

    // Out-of-range write on the six-register instance.
    drive(2'd1, 3'd5, 8'h80, 9'h000, 8'h00, 3'd0, 3'd0);
    check("n6_wr5_flags", 32'(flags[3]), 32'h1);
    drive(2'd1, 3'd7, 8'hFF, 9'h000, 8'h00, 3'd7, 3'd5);
    check("n6_oor_done", 32'(done[3]), 32'h0);
    check("n6_oor_flags", 32'(flags[3]), 32'h1);
    check("n6_oor_rd7", 32'(rd_a[3]), 32'h00);
    check("n6_rd5", 32'(rd_b[3]), 32'h80);
    check("n8_wr7_done", 32'(done[0]), 32'h1);
    drive(2'd0, 3'd0, 8'h00, 9'h000, 8'h00, 3'd3, 3'd2);
    check("n6_rd3", 32'(rd_a[3]), 32'h80);
    check("n6_rd2", 32'(rd_b[3]), 32'h5A);

    // Reset wins over a same-cycle write.
    drive(2'd1, 3'd1, 8'h33, 9'h000, 8'h00, 3'd0, 3'd0);
    Reset = 1'b1;
    drive(2'd1, 3'd1, 8'h44, 9'h000, 8'h00, 3'd1, 3'd1);
    check("rst_mid_rd", 32'(rd_a[0]), 32'h00);
    check("rst_mid_done", 32'(done[0]), 32'h0);
    Reset = 1'b0;
    drive(2'd0, 3'd0, 8'h00, 9'h000, 8'h00, 3'd1, 3'd1);
    check("rst_wr_lost", 32'(rd_a[0]), 32'h00);
    check("rst_flags0", 32'(flags[0]), 32'h0);

    // Random traffic checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] wa;
      logic [2:0] a;
      wa = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7));
      Reset = ($urandom_range(0, 63) == 0);
      drive(2'($urandom_range(0, 3)), wa, 8'($urandom), 9'($urandom), 8'($urandom),
            a, ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7)));
    end
    Reset = 1'b0;
    drive(2'd0, 3'd0, 8'h00, 9'h000, 8'h00, 3'd0, 3'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
